// File: rtl/aer_rx_handshake_pkg.sv
// aer_pkg: definitions shared between the AER receiver and the downstream
// event decoder.
//   AER_DATA_W  : default width of the DAVIS240C address bus
//   aer_state_e : handshake FSM state encoding (also visible on the
//                 receiver's debug port)
//   aer_word_t  : one captured AER address word
package aer_pkg;

  localparam int AER_DATA_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_ACK     = 2'd3
  } aer_state_e;

  typedef logic [AER_DATA_W-1:0] aer_word_t;

endpackage

// File: rtl/aer_rx_handshake_sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous chip pins.
//   clk_i : destination clock
//   rst_i : synchronous active-high reset; both flops load RESET_VAL
//   d_i   : asynchronous input (WIDTH bits, each bit treated independently)
//   q_o   : synchronised output, two clk cycles behind d_i
module sync_2ff #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/aer_rx_handshake.sv
// aer_rx_handshake: receiver end of the DAVIS240C AER bus.
// Synchronises the active-low request, waits for the address bus to settle,
// captures the word into a one-entry output slot, then runs a four-phase
// active-low acknowledge with the chip.
//   clk, rst     : system clock, synchronous active-high reset
//   aer_req_n    : chip request, active low, asynchronous
//   aer_data     : chip address bus, stable while the request is asserted
//   aer_ack_n    : registered acknowledge to the chip, active low
//   m_data       : captured event word
//   m_valid      : m_data holds an unconsumed word
//   m_ready      : downstream accepts the word
//   event_count  : words captured since reset (wraps)
//   err_timeout  : sticky, chip held its request too long in ACK
//   dbg_state    : current handshake FSM state
//
// Stream handshake: a word moves downstream on every clk edge where
// m_valid && m_ready are both high. While m_valid is high and m_ready is low,
// m_data does not change. m_valid never depends combinationally on m_ready.
module aer_rx_handshake
  import aer_pkg::*;
#(
  parameter int DATA_W      = AER_DATA_W,
  parameter int SETTLE_CYC  = 2,
  parameter int ACK_MIN_CYC = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aer_req_n,
  input  logic [DATA_W-1:0] aer_data,
  output logic              aer_ack_n,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       event_count,
  output logic              err_timeout,
  output aer_state_e        dbg_state
);

  localparam int SET_W = $clog2(SETTLE_CYC) + 1;
  localparam int ACK_W = $clog2(ACK_MIN_CYC) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;

  // The IDLE cycle that first sees the request is counted as the first
  // settle cycle, so SETTLE itself lasts SETTLE_CYC-1 cycles.
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE_CYC >= 2) ? (SETTLE_CYC - 2) : 0);
  localparam logic [ACK_W-1:0] ACK_LAST    = ACK_W'(ACK_MIN_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYC - 1);

  aer_state_e        state_q, state_d;
  logic [SET_W-1:0]  set_cnt_q, set_cnt_d;
  logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              ack_n_q, ack_n_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic [31:0]       count_q, count_d;
  logic              err_q, err_d;

  logic req_n_s;
  logic req;
  logic slot_free;
  logic load;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_req_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (aer_req_n),
    .q_o   (req_n_s)
  );

  assign req       = ~req_n_s;
  assign slot_free = ~m_valid_q | m_ready;
  // A request that disappears before capture is a glitch: nothing is loaded.
  assign load      = (state_q == ST_CAPTURE) && req && slot_free;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) state_d = (SETTLE_CYC < 2) ? ST_CAPTURE : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!req)                          state_d = ST_IDLE;
        else if (set_cnt_q == SETTLE_LAST) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!req)           state_d = ST_IDLE;
        else if (slot_free) state_d = ST_ACK;
      end
      ST_ACK: begin
        // ack_cnt_q holds ACK cycles already completed; this one makes +1.
        if (!req && (ack_cnt_q >= ACK_LAST)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    set_cnt_d = '0;
    ack_cnt_d = '0;
    tmo_cnt_d = '0;
    ack_n_d   = (state_d != ST_ACK);
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q & ~m_ready;
    count_d   = count_q;
    err_d     = err_q;

    if (state_q == ST_SETTLE) set_cnt_d = set_cnt_q + SET_W'(1);

    if (state_q == ST_ACK) begin
      ack_cnt_d = (ack_cnt_q == ACK_LAST) ? ack_cnt_q : ack_cnt_q + ACK_W'(1);
      tmo_cnt_d = (tmo_cnt_q == TMO_LAST) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
      if ((state_d == ST_ACK) && (tmo_cnt_q == TMO_LAST)) err_d = 1'b1;
    end

    // A load in the same cycle as a consume keeps m_valid high.
    if (load) begin
      m_data_d  = aer_data;
      m_valid_d = 1'b1;
      count_d   = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      set_cnt_q <= '0;
      ack_cnt_q <= '0;
      tmo_cnt_q <= '0;
      ack_n_q   <= 1'b1;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      set_cnt_q <= set_cnt_d;
      ack_cnt_q <= ack_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      ack_n_q   <= ack_n_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  assign aer_ack_n   = ack_n_q;
  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign event_count = count_q;
  assign err_timeout = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_aer_rx_handshake.sv
// Testbench for aer_rx_handshake: a slave-style chip model drives the AER
// pins; an expected-word queue tracks what the stream must deliver.
module tb_aer_rx_handshake;
  import aer_pkg::*;

  localparam int DW       = 10;
  localparam int SETTLE   = 2;
  localparam int TMO      = 16;
  localparam int FALL_LAT = 2 + SETTLE + 1;
  localparam int RISE_LAT = 3;
  localparam int N_BURST  = 1000;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_n = 1'b1;
  logic [DW-1:0] data = '0;
  logic          ack_n;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [31:0]   event_count;
  logic          err_timeout;
  aer_state_e    dbg_state;

  always #5 clk = ~clk;

  aer_rx_handshake #(
    .DATA_W      (DW),
    .SETTLE_CYC  (SETTLE),
    .ACK_MIN_CYC (1),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .aer_req_n   (req_n),
    .aer_data    (data),
    .aer_ack_n   (ack_n),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .event_count (event_count),
    .err_timeout (err_timeout),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  int            exp_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every accepted word must be the oldest word the chip has offered.
  always @(negedge clk) begin
    if (!rst && (m_valid === 1'b1) && (m_ready === 1'b1)) begin
      if (exp_q.size() == 0) check("stream_extra_word", 32'(m_data), 32'h0001_0000);
      else                   check("stream_word", 32'(m_data), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input logic lvl, input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      #1;
      if (ack_n === lvl) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req_n   = 1'b1;
    m_ready = 1'b0;
    tick(2);
    check("rst_ack_n", 32'(ack_n), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_count", event_count, 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_q.delete();
    exp_count = 0;
    rst = 1'b0;
  endtask

  // Full four-phase handshake with latency checks on both ack edges.
  task automatic send_event(input logic [DW-1:0] w);
    int c;
    data  = w;
    req_n = 1'b0;
    exp_q.push_back(w);
    wait_ack(1'b0, 64, c);
    check("ack_fall_lat", 32'(c), 32'(FALL_LAT));
    exp_count++;
    check("cap_m_valid", 32'(m_valid), 32'd1);
    check("cap_m_data", 32'(m_data), 32'(w));
    check("cap_count", event_count, 32'(exp_count));
    req_n = 1'b1;
    data  = DW'($urandom);
    wait_ack(1'b1, 64, c);
    check("ack_rise_lat", 32'(c), 32'(RISE_LAT));
  endtask

  task automatic drain();
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_m_valid", 32'(m_valid), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int            c;
    logic          low_seen;
    logic [DW-1:0] w;

    // Single event, word held until consumed
    do_reset();
    send_event(10'h2A5);
    tick(2);
    check("single_hold_valid", 32'(m_valid), 32'd1);
    check("single_hold_data", 32'(m_data), 32'h2A5);
    drain();

    // Backpressure: second ack withheld until the slot frees
    do_reset();
    send_event(10'h001);
    data  = 10'h002;
    req_n = 1'b0;
    exp_q.push_back(10'h002);
    tick(20);
    check("bp_ack_withheld", 32'(ack_n), 32'd1);
    check("bp_data_held", 32'(m_data), 32'h001);
    check("bp_valid_held", 32'(m_valid), 32'd1);
    check("bp_count", event_count, 32'd1);
    check("bp_state", 32'(dbg_state), 32'(ST_CAPTURE));
    m_ready = 1'b1;
    wait_ack(1'b0, 8, c);
    m_ready = 1'b0;
    check("bp_release_lat", 32'(c), 32'd1);
    check("bp_reload_data", 32'(m_data), 32'h002);
    check("bp_reload_valid", 32'(m_valid), 32'd1);
    check("bp_count2", event_count, 32'd2);
    req_n = 1'b1;
    wait_ack(1'b1, 16, c);
    check("bp_ack_rise_lat", 32'(c), 32'(RISE_LAT));
    drain();

    // Glitch: request low for two cycles only
    do_reset();
    data     = DW'($urandom);
    req_n    = 1'b0;
    tick(2);
    req_n    = 1'b1;
    low_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (ack_n !== 1'b1) low_seen = 1'b1;
    end
    check("glitch_no_ack", 32'(low_seen), 32'd0);
    check("glitch_count", event_count, 32'd0);
    check("glitch_valid", 32'(m_valid), 32'd0);

    // Timeout: chip holds the request
    do_reset();
    w     = DW'($urandom_range(0, 1023));
    data  = w;
    req_n = 1'b0;
    exp_q.push_back(w);
    wait_ack(1'b0, 64, c);
    check("tmo_ack_lat", 32'(c), 32'(FALL_LAT));
    tick(TMO - 1);
    check("tmo_err_early", 32'(err_timeout), 32'd0);
    tick(1);
    check("tmo_err_set", 32'(err_timeout), 32'd1);
    check("tmo_ack_held", 32'(ack_n), 32'd0);
    tick(10);
    check("tmo_state", 32'(dbg_state), 32'(ST_ACK));
    req_n = 1'b1;
    wait_ack(1'b1, 16, c);
    check("tmo_rise_lat", 32'(c), 32'(RISE_LAT));
    check("tmo_err_sticky", 32'(err_timeout), 32'd1);
    check("tmo_idle", 32'(dbg_state), 32'(ST_IDLE));
    drain();

    // Reset in ACK with request still asserted
    do_reset();
    w     = DW'($urandom_range(0, 1023));
    data  = w;
    req_n = 1'b0;
    exp_q.push_back(w);
    wait_ack(1'b0, 64, c);
    check("rsta_ack_lat", 32'(c), 32'(FALL_LAT));
    rst = 1'b1;
    tick(1);
    check("rsta_ack_n", 32'(ack_n), 32'd1);
    check("rsta_m_valid", 32'(m_valid), 32'd0);
    check("rsta_count", event_count, 32'd0);
    exp_q.delete();
    exp_q.push_back(w);
    rst = 1'b0;
    wait_ack(1'b0, 64, c);
    check("rsta_recap_lat", 32'(c), 32'(FALL_LAT));
    check("rsta_recap_data", 32'(m_data), 32'(w));
    check("rsta_recap_count", event_count, 32'd1);
    req_n = 1'b1;
    wait_ack(1'b1, 16, c);
    check("rsta_rise_lat", 32'(c), 32'(RISE_LAT));
    drain();

    // Burst: back-to-back random words, stream always ready
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < N_BURST; i++) send_event(DW'($urandom_range(0, 1023)));
    tick(3);
    m_ready = 1'b0;
    check("burst_all_delivered", 32'(exp_q.size()), 32'd0);
    check("burst_count", event_count, 32'(N_BURST));
    check("burst_no_err", 32'(err_timeout), 32'd0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

endmodule
